// File: rtl/can_tail_tx.sv
// CAN frame tail sequencer: CRC delimiter, ACK slot/delimiter, EOF and intermission.
// Build option: `define OVERLOAD_DETECT_EN to flag dominant bits in IFS bits 0-1 as overload.
module can_tail_tx #(
   parameter int unsigned EOF_BITS = 7,
   parameter int unsigned IFS_BITS = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic bit_tick,
   input  logic sp,
   input  logic start,
   input  logic ack_en,
   input  logic rx,
   output logic tx,
   output logic busy,
   output logic done,
   output logic ack_err,
   output logic form_err,
   output logic overload
);

   localparam int unsigned MAX_BITS = (EOF_BITS > IFS_BITS) ? EOF_BITS : IFS_BITS;
   localparam int unsigned CNT_W    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
`ifdef OVERLOAD_DETECT_EN
   localparam bit OVL_EN = 1'b1;
`else
   localparam bit OVL_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_CRC_DEL,
      S_ACK_SLOT,
      S_ACK_DEL,
      S_EOF,
      S_IFS
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             role_q, role_d;
   logic             tx_q, tx_d;
   logic             done_q, done_d;
   logic             ack_err_q, ack_err_d;
   logic             form_err_q, form_err_d;
   logic             ovl_q, ovl_d;
   logic             abort;

   assign abort = ack_err_q | form_err_q | ovl_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      role_d     = role_q;
      ack_err_d  = ack_err_q;
      form_err_d = form_err_q;
      ovl_d      = ovl_q;

      // Samples judge the state being left, even when bit_tick coincides.
      if (sp) begin
         unique case (state_q)
            S_CRC_DEL, S_ACK_DEL, S_EOF: if (!rx) form_err_d = 1'b1;
            S_ACK_SLOT: if (!role_q && rx) ack_err_d = 1'b1;
            S_IFS: if (OVL_EN && !rx && (cnt_q < CNT_W'(2))) ovl_d = 1'b1;
            default: ;
         endcase
      end

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_ARMED;
               cnt_d      = '0;
               role_d     = ack_en;
               ack_err_d  = 1'b0;
               form_err_d = 1'b0;
               ovl_d      = 1'b0;
            end
         end
         S_ARMED: if (bit_tick) state_d = S_CRC_DEL;
         default: begin
            if (bit_tick) begin
               if (abort) begin
                  state_d = S_IDLE;
               end else begin
                  unique case (state_q)
                     S_CRC_DEL:  state_d = S_ACK_SLOT;
                     S_ACK_SLOT: state_d = S_ACK_DEL;
                     S_ACK_DEL: begin
                        state_d = S_EOF;
                        cnt_d   = '0;
                     end
                     S_EOF: begin
                        if (cnt_q == CNT_W'(EOF_BITS - 1)) begin
                           state_d = S_IFS;
                           cnt_d   = '0;
                        end else begin
                           cnt_d = cnt_q + 1'b1;
                        end
                     end
                     S_IFS: begin
                        if (cnt_q == CNT_W'(IFS_BITS - 1)) begin
                           state_d = S_IDLE;
                           cnt_d   = '0;
                        end else begin
                           cnt_d = cnt_q + 1'b1;
                        end
                     end
                     default: state_d = S_IDLE;
                  endcase
               end
            end
         end
      endcase

      done_d = (state_d == S_IDLE) && (state_q != S_IDLE);
      tx_d   = !((state_d == S_ACK_SLOT) && role_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         role_q     <= 1'b0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
         ack_err_q  <= 1'b0;
         form_err_q <= 1'b0;
         ovl_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         role_q     <= role_d;
         tx_q       <= tx_d;
         done_q     <= done_d;
         ack_err_q  <= ack_err_d;
         form_err_q <= form_err_d;
         ovl_q      <= ovl_d;
      end
   end

   assign tx       = tx_q;
   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign ack_err  = ack_err_q;
   assign form_err = form_err_q;
   assign overload = ovl_q;

endmodule

// File: tb/tb_can_tail_tx.sv
// Bench for can_tail_tx: vector table of whole-frame scenarios plus reset/coincident-strobe sequences.
module tb_can_tail_tx;

`ifdef OVERLOAD_DETECT_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset, bit_tick, sp, start, ack_en, rx;
   logic tx, busy, done, ack_err, form_err, overload;

   int n_tests = 0;
   int n_fail  = 0;

   // dom[b] = 1 drives a dominant rx at the sample point of tail bit b
   // (0 CRC_DEL, 1 ACK_SLOT, 2 ACK_DEL, 3..9 EOF0..6, 10..12 IFS0..2).
   typedef struct {
      string       name;
      logic        ack_en;
      logic [12:0] dom;
      int          done_tick;
      logic        e_ack;
      logic        e_form;
      logic        e_ovl;
   } vec_t;

   typedef struct {
      int   done_tick;
      logic e_ack;
      logic e_form;
      logic e_ovl;
   } res_t;

   res_t res_q[$];
   logic exp_tx_q[$];
   vec_t vecs[11];

   always #5 clk = ~clk;

   can_tail_tx #(.EOF_BITS(7), .IFS_BITS(3)) dut (
      .clk      (clk),
      .reset    (reset),
      .bit_tick (bit_tick),
      .sp       (sp),
      .start    (start),
      .ack_en   (ack_en),
      .rx       (rx),
      .tx       (tx),
      .busy     (busy),
      .done     (done),
      .ack_err  (ack_err),
      .form_err (form_err),
      .overload (overload)
   );

   task automatic chk(input string nm, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", nm, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_tick();
      bit_tick = 1'b1;
      cyc();
      bit_tick = 1'b0;
   endtask

   task automatic pulse_sp(input logic r);
      rx = r;
      sp = 1'b1;
      cyc();
      sp = 1'b0;
      rx = 1'b1;
   endtask

   task automatic do_start(input logic role);
      ack_en = role;
      start  = 1'b1;
      cyc();
      start  = 1'b0;
      ack_en = 1'b0;
   endtask

   task automatic run_frame(input vec_t v);
      res_t r;
      int   got;
      logic etx;
      got = -1;
      r.done_tick = v.done_tick;
      r.e_ack     = v.e_ack;
      r.e_form    = v.e_form;
      r.e_ovl     = v.e_ovl;
      res_q.push_back(r);
      do_start(v.ack_en);
      chk({v.name, "/busy_start"}, busy, 1'b1);
      chk({v.name, "/flags_clr"}, ack_err | form_err | overload, 1'b0);
      for (int k = 1; k <= 16 && got < 0; k++) begin
         if (k >= 2 && k <= 14) pulse_sp(v.dom[k-2] ? 1'b0 : 1'b1);
         etx = !(k == 2 && v.ack_en && v.done_tick != 2);
         exp_tx_q.push_back(etx);
         pulse_tick();
         chk({v.name, "/tx"}, tx, exp_tx_q.pop_front());
         if (done) got = k;
         else chk({v.name, "/busy_run"}, busy, 1'b1);
      end
      r = res_q.pop_front();
      chk_int({v.name, "/done_tick"}, got, r.done_tick);
      chk({v.name, "/ack_err"}, ack_err, r.e_ack);
      chk({v.name, "/form_err"}, form_err, r.e_form);
      chk({v.name, "/overload"}, overload, r.e_ovl);
      chk({v.name, "/busy_end"}, busy, 1'b0);
      cyc();
      chk({v.name, "/done_pulse"}, done, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{"tx_clean",   1'b0, 13'h0002, 14, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{"rx_ack",     1'b1, 13'h0002, 14, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{"no_ack",     1'b0, 13'h0000,  3, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{"rcv_nochk",  1'b1, 13'h0000, 14, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{"crc_del",    1'b0, 13'h0003,  2, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{"ack_del",    1'b0, 13'h0006,  4, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{"eof0",       1'b1, 13'h000A,  5, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{"eof6",       1'b0, 13'h0202, 11, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{"ifs0",       1'b0, 13'h0402, OVL ? 12 : 14, 1'b0, 1'b0, OVL};
      vecs[9]  = '{"ifs1",       1'b1, 13'h0802, OVL ? 13 : 14, 1'b0, 1'b0, OVL};
      vecs[10] = '{"ifs2_sof",   1'b0, 13'h1002, 14, 1'b0, 1'b0, 1'b0};

      reset = 1'b1; bit_tick = 1'b0; sp = 1'b0; start = 1'b0; ack_en = 1'b0; rx = 1'b1;
      cyc(); cyc(); cyc();
      chk("rst/tx", tx, 1'b1);
      chk("rst/busy", busy, 1'b0);
      chk("rst/done", done, 1'b0);
      chk("rst/ack_err", ack_err, 1'b0);
      chk("rst/form_err", form_err, 1'b0);
      chk("rst/overload", overload, 1'b0);
      reset = 1'b0;
      cyc();

      for (int i = 0; i < 11; i++) begin
         run_frame(vecs[i]);
         cyc();
      end

      // Reset during EOF bit 3: immediate IDLE, no done pulse.
      do_start(1'b1);
      for (int k = 1; k <= 7; k++) pulse_tick();
      chk("midrst/busy_pre", busy, 1'b1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("midrst/tx", tx, 1'b1);
      chk("midrst/busy", busy, 1'b0);
      chk("midrst/done", done, 1'b0);
      for (int k = 0; k < 3; k++) begin
         pulse_tick();
         chk("midrst/no_done", done, 1'b0);
      end

      // start while busy must neither clear ack_err nor relatch the role.
      do_start(1'b0);
      pulse_tick();
      pulse_tick();
      chk("busystart/tx_ack", tx, 1'b1);
      pulse_sp(1'b1);
      chk("busystart/ack_set", ack_err, 1'b1);
      do_start(1'b1);
      chk("busystart/ack_kept", ack_err, 1'b1);
      chk("busystart/busy", busy, 1'b1);
      pulse_tick();
      chk("busystart/done", done, 1'b1);
      chk("busystart/tx_after", tx, 1'b1);
      cyc();

      // sp and bit_tick together on ACK_DEL: flag from ACK_DEL, abort one tick later.
      do_start(1'b1);
      pulse_tick();
      pulse_tick();
      chk("coinc/tx_ack", tx, 1'b0);
      pulse_tick();
      rx = 1'b0; sp = 1'b1; bit_tick = 1'b1;
      cyc();
      rx = 1'b1; sp = 1'b0; bit_tick = 1'b0;
      chk("coinc/form_err", form_err, 1'b1);
      chk("coinc/busy", busy, 1'b1);
      chk("coinc/no_done", done, 1'b0);
      pulse_tick();
      chk("coinc/done", done, 1'b1);
      chk("coinc/busy_end", busy, 1'b0);
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
